// File: rtl/sar_search_ctrl_pkg.sv
// Shared types for the successive-approximation search controller:
// FSM state encoding, comparator flag bundle and the flag legality check.
package sar_search_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TRY   = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } sar_state_e;

  // Comparator response: gt (a>b), eq (a==b), lt (a<b).
  typedef struct packed {
    logic gt;
    logic eq;
    logic lt;
  } cmp_flags_t;

  // A healthy comparator raises exactly one of its three flags.
  function automatic logic onehot3(input cmp_flags_t f);
    return ( f.gt & ~f.eq & ~f.lt) |
           (~f.gt &  f.eq & ~f.lt) |
           (~f.gt & ~f.eq &  f.lt);
  endfunction

endpackage

// File: rtl/sar_search_ctrl.sv
// Successive-approximation controller. Drives candidate values onto the
// comparator "a" input MSB-first, narrows toward the value on "b" using the
// gt/eq/lt flags, exits early on an exact match and flags an illegal
// (not one-hot) comparator response as a sticky error.
module sar_search_ctrl
  import sar_search_ctrl_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             cmp_gt,
  input  logic             cmp_eq,
  input  logic             cmp_lt,
  output logic [WIDTH-1:0] trial,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             found,
  output logic             err
);

  localparam int KW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [WIDTH-1:0] ONE    = WIDTH'(1);
  localparam logic [WIDTH-1:0] MSB    = ONE << (WIDTH - 1);
  localparam logic [KW-1:0]    K_INIT = KW'(WIDTH - 1);

  sar_state_e       state_q, state_d;
  logic [WIDTH-1:0] trial_q, trial_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [KW-1:0]    k_q, k_d;
  logic             found_q, found_d;
  logic             err_q, err_d;

  cmp_flags_t       flags;
  logic             flagsOk;
  logic [WIDTH-1:0] bitK;
  logic [WIDTH-1:0] trialCleared;

  assign flags.gt = cmp_gt;
  assign flags.eq = cmp_eq;
  assign flags.lt = cmp_lt;
  assign flagsOk  = onehot3(flags);

  // bitK is the bit under test; when the trial overshoots it gets dropped.
  assign bitK         = ONE << k_q;
  assign trialCleared = cmp_gt ? (trial_q & ~bitK) : trial_q;

  // State register and datapath registers, synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      trial_q  <= '0;
      result_q <= '0;
      k_q      <= '0;
      found_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      trial_q  <= trial_d;
      result_q <= result_d;
      k_q      <= k_d;
      found_q  <= found_d;
      err_q    <= err_d;
    end
  end

  // Next-state and datapath update; everything holds unless a state says otherwise.
  always_comb begin
    state_d  = state_q;
    trial_d  = trial_q;
    result_d = result_q;
    k_d      = k_q;
    found_d  = found_q;
    err_d    = err_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          k_d      = K_INIT;
          trial_d  = MSB;
          result_d = '0;
          found_d  = 1'b0;
          err_d    = 1'b0;
          state_d  = TRY;
        end
      end

      TRY: begin
        if (!flagsOk) begin
          err_d    = 1'b1;
          found_d  = 1'b0;
          result_d = trial_q;
          state_d  = DONE;
        end else if (cmp_eq) begin
          result_d = trial_q;
          found_d  = 1'b1;
          state_d  = DONE;
        end else if (k_q != '0) begin
          trial_d = trialCleared | (bitK >> 1);
          k_d     = k_q - KW'(1);
        end else begin
          trial_d = trialCleared;
          state_d = CHECK;
        end
      end

      CHECK: begin
        if (!flagsOk) begin
          err_d = 1'b1;
        end
        result_d = trial_q;
        found_d  = cmp_eq;
        state_d  = DONE;
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign trial  = trial_q;
  assign result = result_q;
  assign found  = found_q;
  assign err    = err_q;
  assign busy   = (state_q == TRY) || (state_q == CHECK);
  assign done   = (state_q == DONE);

endmodule

// File: tb/tb_sar_search_ctrl.sv
// Directed bench for sar_search_ctrl with a behavioural magnitude comparator
// in the loop (target on b, trial on a) and an override to inject illegal flags.
module tb_sar_search_ctrl;

  localparam int WIDTH = 4;

  logic             clk;
  logic             rst;
  logic             start;
  logic             cmpGt, cmpEq, cmpLt;
  logic [WIDTH-1:0] trial;
  logic             busy, done, found, err;
  logic [WIDTH-1:0] result;

  logic [WIDTH-1:0] target;
  logic             forceEn;

  int checkCount;
  int errorCount;

  sar_search_ctrl #(.WIDTH(WIDTH)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .cmp_gt (cmpGt),
    .cmp_eq (cmpEq),
    .cmp_lt (cmpLt),
    .trial  (trial),
    .busy   (busy),
    .done   (done),
    .result (result),
    .found  (found),
    .err    (err)
  );

  // Comparator model; the override forces all three flags low.
  assign cmpGt = forceEn ? 1'b0 : (trial >  target);
  assign cmpEq = forceEn ? 1'b0 : (trial == target);
  assign cmpLt = forceEn ? 1'b0 : (trial <  target);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checkCount++;
    if (observed != expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // Runs one search from IDLE and checks trial sequence, latency and outcome.
  task automatic applyStimulus(input string name, input int tgt, input int nExp,
                               input int expTrials[5], input int expDone,
                               input int expResult, input int expFound,
                               input int expErr, input bit holdStart,
                               input bit forceBad);
    int cyc;
    int nTr;
    int trials[8];
    bit seen;
    @(negedge clk);
    target  = tgt[WIDTH-1:0];
    forceEn = forceBad;
    start   = 1'b1;
    cyc  = 0;
    nTr  = 0;
    seen = 1'b0;
    while (!seen && cyc < 20) begin
      @(negedge clk);
      cyc++;
      if (!holdStart) start = 1'b0;
      if (cyc == 1) begin
        checkOutput({name, ".errClearedOnStart"}, int'(err), 0);
        checkOutput({name, ".busyAfterStart"}, int'(busy), 1);
      end
      if (done) begin
        seen  = 1'b1;
        start = 1'b0;
      end else if (busy) begin
        if (nTr < 8) trials[nTr] = int'(trial);
        nTr++;
      end
    end
    forceEn = 1'b0;
    checkOutput({name, ".doneSeen"}, int'(seen), 1);
    checkOutput({name, ".doneCycle"}, cyc, expDone);
    checkOutput({name, ".trialCount"}, nTr, nExp);
    for (int i = 0; i < nExp && i < nTr && i < 5; i++)
      checkOutput($sformatf("%s.trial%0d", name, i), trials[i], expTrials[i]);
    checkOutput({name, ".result"}, int'(result), expResult);
    checkOutput({name, ".found"}, int'(found), expFound);
    checkOutput({name, ".err"}, int'(err), expErr);
    checkOutput({name, ".busyInDone"}, int'(busy), 0);
    @(negedge clk);
    checkOutput({name, ".donePulseOnce"}, int'(done), 0);
    checkOutput({name, ".idleAfterDone"}, int'(busy), 0);
    checkOutput({name, ".resultHeld"}, int'(result), expResult);
  endtask

  initial begin
    checkCount = 0;
    errorCount = 0;
    rst     = 1'b1;
    start   = 1'b0;
    target  = '0;
    forceEn = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("reset.trial", int'(trial), 0);
    checkOutput("reset.result", int'(result), 0);
    checkOutput("reset.busy", int'(busy), 0);
    checkOutput("reset.done", int'(done), 0);
    checkOutput("reset.found", int'(found), 0);
    checkOutput("reset.err", int'(err), 0);
    rst = 1'b0;
    @(negedge clk);

    applyStimulus("t6",  6,  3, '{8, 4, 6, 0, 0},   4, 6,  1, 0, 1'b0, 1'b0);
    applyStimulus("t0",  0,  5, '{8, 4, 2, 1, 0},   6, 0,  1, 0, 1'b0, 1'b0);
    applyStimulus("t15", 15, 4, '{8, 12, 14, 15, 0}, 5, 15, 1, 0, 1'b0, 1'b0);
    applyStimulus("bad", 3,  1, '{8, 0, 0, 0, 0},   2, 8,  0, 1, 1'b0, 1'b1);
    applyStimulus("t9",  9,  4, '{8, 12, 10, 9, 0}, 5, 9,  1, 0, 1'b0, 1'b0);
    applyStimulus("hold9", 9, 4, '{8, 12, 10, 9, 0}, 5, 9, 1, 0, 1'b1, 1'b0);

    // Reset in the middle of a search for target 5.
    @(negedge clk);
    target = 4'd5;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checkOutput("rstMid.trial1", int'(trial), 8);
    @(negedge clk);
    checkOutput("rstMid.trial2", int'(trial), 4);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("rstMid.trial", int'(trial), 0);
    checkOutput("rstMid.busy", int'(busy), 0);
    checkOutput("rstMid.done", int'(done), 0);
    checkOutput("rstMid.result", int'(result), 0);
    checkOutput("rstMid.found", int'(found), 0);
    checkOutput("rstMid.err", int'(err), 0);
    @(negedge clk);
    checkOutput("rstMid.noDone", int'(done), 0);
    checkOutput("rstMid.staysIdle", int'(busy), 0);

    applyStimulus("t5", 5, 4, '{8, 4, 6, 5, 0}, 5, 5, 1, 0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule

// File: doc/sar_search_ctrl.md
Name: sar_search_ctrl

Overview:
- Successive-approximation controller that drives the "a" side of the magnitude comparator and consumes its gt/eq/lt flags to find an unknown value held on the comparator's "b" input.
- Resolves the value MSB-first in at most WIDTH+1 compare cycles.
- Exits early on an exact match.
- Flags non-one-hot comparator responses as an error.

Parameters:
- WIDTH, 4, bit width of trial/result; must match the comparator width (≥2)

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  reset
- start  input  1  request a new search; sampled only in IDLE
- cmp_gt  input  1  comparator a>b flag (y0)
- cmp_eq  input  1  comparator a==b flag (y1)
- cmp_lt  input  1  comparator a<b flag (y2)
- trial  output  WIDTH  candidate value driven to comparator input a; registered
- busy  output  1  high in TRY and CHECK
- done  output  1  one-cycle pulse when result/found/err are valid
- result  output  WIDTH  converged value; held until next accepted start
- found  output  1  1 when the final result was confirmed equal
- err  output  1  comparator flags not one-hot during search; held until next accepted start

Interface note: one clock; reset is synchronous and active-high (clk, rst).

Behaviour:
- Reset (rst=1 at rising edge, any state including mid-search):
  - state=IDLE.
  - trial, result, bit index = 0.
  - busy, done, found, err = 0.
- Comparator is combinational: flags are valid in the same cycle trial is presented. Flags are sampled at the end of every TRY/CHECK cycle.
- States: IDLE, TRY, CHECK, DONE.
- IDLE, start=1:
  - k=WIDTH-1; trial=1<<(WIDTH-1).
  - found, err, result cleared.
  - Go to TRY. busy rises next cycle.
- TRY (testing bit k), priority order:
  1. Flags not exactly one-hot (none or multiple set): err=1, found=0, result=trial, go to DONE.
  2. cmp_eq: result=trial, found=1, go to DONE (early exit).
  3. k>0: t=cmp_gt ? trial&~(1<<k) : trial; trial=t|(1<<(k-1)); k=k-1; stay in TRY.
  4. k==0: trial = cmp_gt ? trial&~1 : trial; go to CHECK.
- CHECK: final trial is presented.
  - Flags not one-hot: err=1.
  - result=trial.
  - found=cmp_eq.
  - Go to DONE.
- DONE:
  - done=1 for exactly this cycle; busy=0.
  - Next state IDLE; trial keeps its last value.
- start is ignored outside IDLE, including in DONE. No queuing.
- Latency from start edge to done:
  - Exact match found at bit k: (WIDTH-k)+1 cycles.
  - Worst case: WIDTH+2 cycles (WIDTH TRY + CHECK + DONE).
- Without a match the result is the largest value ≤ target, which equals target for any in-range target. found=0 occurs only with an err or a target that changes mid-search.
- Target changing mid-search is not supported. Result is undefined but the FSM still terminates.
- err is sticky until the next accepted start.

Decomposition:
- Shared package holds:
  - State encoding enum (IDLE/TRY/CHECK/DONE, 2 bits).
  - Comparator flag-bundle typedef {gt,eq,lt}.
  - Function onehot3() for the flag legality check.
- No sub-module is required. The bench instantiates the existing comparator with the target tied to b, trial to a, y0/y1/y2 to cmp_gt/cmp_eq/cmp_lt.

Test Plan (WIDTH=4, real comparator in loop):
- target=6, start pulse → trials 8,4,6; eq on third TRY; done 4 cycles after start; result=6, found=1, err=0.
- target=0 → trials 8,4,2,1, CHECK presents 0; done at cycle 6; result=0, found=1 (worst-case latency).
- target=15 → trials 8,12,14,15; eq at k=0; result=15, found=1, done at cycle 5; CHECK not entered.
- Force cmp_gt=cmp_lt=0, cmp_eq=0 during first TRY → err=1, found=0, result=8, done next cycle. A following start with the real comparator and target=9 clears err; result=9, found=1.
- target=9, assert start every cycle during the search → only the first start accepted; trials 8,12,10,9; exactly one done pulse.
- target=5, rst=1 during second TRY → next cycle state IDLE, all outputs 0, no done pulse. A subsequent start gives result=5, found=1.
